rf_mp: RTL
==========

# rf_mp

Parametrised multi-port register file for the pico core, replacing the fixed two-read-port file. It provides NR combinational read ports and one write port with optional write-through bypass. It also provides a per-register pending-write scoreboard for pipeline hazard detection. Register 0 is hardwired to zero, one address is a synchronised external input, and one address drives an external output. It sits between decode (read addresses, scoreboard set) and writeback (write port).

## Interface
Parameters:
- N, pico::N: data width.
- R, pico::R: register count; power of two, ≥ 4.
- NR, 2: number of read ports, 1..4.
- EXT_ADDR, 30: read-only external-input register.
- OUT_ADDR, 31: register mirrored to ext_data_o.
- SYNC_STAGES, 2: external-input synchroniser depth, ≥ 1.
- BYPASS, 1: 1 enables same-cycle write-to-read forwarding.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- wr_en_i  in  1  writeback strobe.
- wr_addr_i  in  $clog2(R)  write address.
- wr_data_i  in  N signed  write data.
- rd_addr_i  in  NR×$clog2(R)  read addresses, one per port.
- rd_data_o  out  NR×N signed  read data, combinational.
- busy_set_i  in  1  decode issued an instruction that will write busy_addr_i.
- busy_addr_i  in  $clog2(R)  scoreboard set address.
- busy_o  out  NR  read port k targets a register with a pending write.
- ext_data_i  in  N  asynchronous external input.
- ext_data_o  out  N  registered copy of register OUT_ADDR.

## Operation
- Reset (rst_ni=0 at an edge): all registers, sync stages and scoreboard bits become 0; ext_data_o=0 and busy_o=0 from the following cycle. Reset overrides every write and set in that cycle.
- Address 0: always reads 0. Writes and busy sets to it are ignored, and it is never busy.
- Address EXT_ADDR:
  - ext_data_i passes through a SYNC_STAGES-deep flop chain.
  - The last stage is register EXT_ADDR.
  - Writes and busy sets to it are ignored, and it is never busy.
  - Bypass never applies to it.
- Other addresses: register wr_addr_i ← wr_data_i at the edge when wr_en_i=1.
- Read port k: rd_data_o[k] = regs[rd_addr_i[k]].
  - If BYPASS=1, wr_en_i=1 and wr_addr_i==rd_addr_i[k] (writable address), rd_data_o[k] = wr_data_i instead.
  - All ports are independent, and any number may read the same address.
- Scoreboard, one bit per register:
  - Set at the edge by busy_set_i.
  - Cleared at the edge by wr_en_i to the same address.
  - Simultaneous set and clear of the same address: set wins, because a new producer is pending.
- busy_o[k] = busy[rd_addr_i[k]], masked to 0 when BYPASS=1 and the same-cycle write hits that address and is forwarded.
- ext_data_o takes the value of register OUT_ADDR; it updates at the same edge as the register write, so it is one cycle after wr_en_i.
- Elaboration errors when any of these hold:
  - EXT_ADDR==OUT_ADDR.
  - EXT_ADDR or OUT_ADDR is 0.
  - EXT_ADDR or OUT_ADDR is ≥R.
  - NR is outside 1..4.

## Timing
- Read latency: 0 cycles (combinational from rd_addr_i).
- Write-to-read: same cycle with BYPASS=1; next cycle with BYPASS=0.
- External input: a change on ext_data_i is readable after SYNC_STAGES edges.
- Scoreboard: busy_o is high from the cycle after busy_set_i.
- Reset mid-operation: pending busy bits are dropped, and in-flight sync data is discarded.

## Structure
- The pico package holds N, R, the register-address typedef and a constant for the zero register.
- The package also holds EXT/OUT address defaults, so decode uses the same constants.
- One sub-module, `rf_sync`: an N-bit, SYNC_STAGES-deep synchroniser with synchronous active-low reset.
- Storage, bypass mux and scoreboard stay in rf_mp.

## Test plan
- Reset, then read all addresses on every port → all 0, busy_o=0, ext_data_o=0. Write 8'h5A to r0 → r0 still reads 0.
- Write r5=8'h33 with rd_addr_i[0]=5 in the same cycle:
  - BYPASS=1 → rd_data_o[0]=8'h33 immediately.
  - BYPASS=0 → old value that cycle, 8'h33 the next.
- busy_set_i on r7, then wr_en_i to r7 two cycles later:
  - busy_o high for the 2 cycles in between.
  - Same-cycle busy_o=0 with BYPASS=1.
  - Clear afterwards.
- Simultaneous busy_set_i and write to r9 → r9 takes the data and remains busy.
- ext_data_i=8'hC3 held → r30 reads 8'hC3 after exactly 2 edges; a write of 8'h11 to r30 is ignored.
- Write 8'h7E to r31 → ext_data_o=8'h7E next cycle. Assert rst_ni=0 → ext_data_o=0 after that edge.

Source files
------------

// File: rtl/rf_mp_pkg.sv
// pico: shared core constants, register-address type and special register addresses.
package pico;
    localparam int N = 8;
    localparam int R = 32;
    localparam int AW = $clog2(R);
    typedef logic [AW-1:0] reg_addr_t;
    localparam reg_addr_t ZERO_REG = '0;
    localparam int EXT_ADDR_DEF = 30;
    localparam int OUT_ADDR_DEF = 31;
endpackage

// File: rtl/rf_mp_sync.sv
// rf_sync: W-bit, STAGES-deep flop chain bringing an asynchronous input into clk_i.
module rf_sync #(
    parameter int W = 8,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] sync_q [STAGES];
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end
    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/rf_mp.sv
// rf_mp: NR-read/1-write register file with write-through bypass, pending-write scoreboard,
// hardwired zero register, synchronised external input register and mirrored output register.
module rf_mp #(
    parameter int N = pico::N,
    parameter int R = pico::R,
    parameter int NR = 2,
    parameter int EXT_ADDR = pico::EXT_ADDR_DEF,
    parameter int OUT_ADDR = pico::OUT_ADDR_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_en_i,
    input  logic [$clog2(R)-1:0]       wr_addr_i,
    input  logic signed [N-1:0]        wr_data_i,
    input  logic [NR*$clog2(R)-1:0]    rd_addr_i,
    output logic [NR*N-1:0]            rd_data_o,
    input  logic                       busy_set_i,
    input  logic [$clog2(R)-1:0]       busy_addr_i,
    output logic [NR-1:0]              busy_o,
    input  logic [N-1:0]               ext_data_i,
    output logic [N-1:0]               ext_data_o
);
    localparam int AW = $clog2(R);

    if (EXT_ADDR == OUT_ADDR || EXT_ADDR == 0 || OUT_ADDR == 0 || EXT_ADDR >= R || OUT_ADDR >= R ||
        NR < 1 || NR > 4 || R < 4 || (R & (R - 1)) != 0 || SYNC_STAGES < 1) begin : g_bad_cfg
        $error("rf_mp: illegal parameter combination");
    end

    logic [N-1:0] regs_q [R];
    logic [R-1:0] busy_q, busy_d;
    logic [N-1:0] ext_q;

    function automatic logic writable(logic [AW-1:0] a);
        return a != '0 && a != AW'(EXT_ADDR);
    endfunction

    rf_sync #(.W(N), .STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (ext_data_i),
        .q_o    (ext_q)
    );

    // A new producer issued in the same cycle as the old one's writeback keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_i && writable(wr_addr_i)) busy_d[wr_addr_i] = 1'b0;
        if (busy_set_i && writable(busy_addr_i)) busy_d[busy_addr_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < R; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            if (wr_en_i && writable(wr_addr_i)) regs_q[wr_addr_i] <= wr_data_i;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic hit;
        assign ra = rd_addr_i[k*AW +: AW];
        assign hit = BYPASS != 0 && wr_en_i && wr_addr_i == ra && writable(ra);
        assign rd_data_o[k*N +: N] = hit ? wr_data_i : ra == '0 ? '0 : ra == AW'(EXT_ADDR) ? ext_q : regs_q[ra];
        assign busy_o[k] = busy_q[ra] && !hit;
    end

    assign ext_data_o = regs_q[OUT_ADDR];
endmodule
